cic_rate_sequencer: RTL
=======================

// Module: cic_rate_sequencer
// PURPOSE
//  Sequences decimation-rate changes for the two-stage CIC chain (first CIC then second CIC) on each receiver.
//  Maps a requested rate code to the (dec1, dec2) pair and clears the CIC accumulators.
//  Blanks output samples until the comb pipeline has refilled, then hands samples downstream with a valid gate.
//  Sits between the control/command decoder and the receiver's CIC instances.
// PARAMETERS
//  CLEAR_CYCLES    4      cycles cic_clear held high per change (>=1)
//  SETTLE_SAMPLES  11     cic2 output strobes discarded after clear (>= cic2 STAGES)
//  TIMEOUT_CYCLES  65535  SETTLE watchdog limit (used only with SETTLE_TIMEOUT_EN)
// PORTS
//  clock        in   1  system clock
//  reset        in   1  synchronous, active-high
//  rate_req     in   3  requested rate code; sampled only when rate_load=1
//  rate_load    in   1  one-cycle request strobe
//  cic2_strobe  in   1  out_strobe of the second CIC (one per output sample)
//  dec1         out  8  decimation of the first CIC
//  dec2         out  7  decimation of the second CIC
//  cic_clear    out  1  synchronous clear to both CICs' integrator/comb registers
//  out_gate     out  1  1 = cic2_strobe samples are valid downstream
//  rate_cur     out  3  code currently applied
//  rate_ack     out  1  one-cycle pulse on entry to RUN after a change
//  busy         out  1  1 in any state other than RUN
//  rate_err     out  1  one-cycle pulse: invalid code or settle timeout
// BEHAVIOUR
//  Clock and reset: single clock; reset is synchronous and active-high.
//  Rate table, code -> dec1 x dec2 (total):
//    0 -> 40x20 (800); 1 -> 20x20 (400); 2 -> 10x20 (200); 3 -> 5x20 (100); 4 -> 5x10 (50).
//  Codes 5..7 are invalid: rate_err pulses the next cycle; state, pending and rate_cur are unchanged.
//  Reset values: state=CLEAR, clr_cnt=0, rate_cur=0, dec1=40, dec2=20, cic_clear=1, out_gate=0,
//    busy=1, rate_ack=0, rate_err=0, pending empty.
//  Reset mid-operation: abandons any change and restarts the CLEAR sequence with code 0.
//  FSM states: RUN, CLEAR, SETTLE. All outputs are registered.
//  RUN:
//    - out_gate=1, cic_clear=0.
//    - Valid rate_load with rate_req != rate_cur: next cycle rate_cur/dec1/dec2 update, out_gate=0,
//      state -> CLEAR.
//    - Valid rate_load with rate_req == rate_cur: ignored, no ack.
//  CLEAR:
//    - cic_clear=1 for exactly CLEAR_CYCLES cycles, then state -> SETTLE with settle count=0.
//    - The dec values are stable for the whole clear, so sample_no counters restart under the new rate.
//  SETTLE:
//    - Count cic2_strobe pulses; a strobe in the same cycle as the CLEAR->SETTLE entry is not counted.
//    - When the count reaches SETTLE_SAMPLES: state -> RUN, rate_ack=1 for 1 cycle, out_gate=1 next cycle.
//    - The gate opens on the strobe after the SETTLE_SAMPLES-th discarded one.
//  Pending request (valid rate_load seen in CLEAR or SETTLE):
//    - Stored in a single pending register; the last request wins.
//    - On the cycle RUN would be entered, a pending code != rate_cur skips RUN: state -> CLEAR with the
//      new code, no rate_ack; pending is emptied.
//    - A pending code == rate_cur is dropped and RUN is entered with rate_ack as normal.
//  Simultaneous rate_load and the completing cic2_strobe: the request is treated as pending (rule above).
//  busy = (state != RUN); it falls in the same cycle rate_ack rises.
// CONFIGURATION
//  SETTLE_TIMEOUT_EN defined:
//    - A cycle counter runs in SETTLE and is reset by each cic2_strobe.
//    - At TIMEOUT_CYCLES with no strobe: rate_err pulses and state -> RUN with rate_ack=1.
//  SETTLE_TIMEOUT_EN undefined: no counter; SETTLE waits indefinitely for strobes.
// STRUCTURE
//  Shared package (cic_pkg):
//    - rate code typedef (3 bits) and the state enum.
//    - DEC1_TABLE/DEC2_TABLE constants and the RATE_CODE_MAX = 4 constant.
//  The CIC modules use the same table constants for their msb selection.
//  One sub-module: cic_rate_lut (combinational code -> dec1, dec2, valid), reused by the TX/RX config paths.
//  The FSM, counters and pending register stay in this module.
// TESTING
//  1. Reset released, cic2_strobe every 800 clk -> cic_clear high 4 cycles; out_gate rises after the 11th strobe;
//     dec1=40, dec2=20.
//  2. In RUN, rate_req=3 with rate_load -> next cycle dec1=5, dec2=20, out_gate=0; cic_clear for 4 cycles;
//     rate_ack after 11 strobes.
//  3. rate_req=6 with rate_load in RUN -> rate_err pulse; rate_cur, dec1, dec2 and out_gate unchanged.
//  4. In SETTLE: load code 1 then code 4 -> after settling the FSM re-enters CLEAR with code 4, no intermediate
//     ack; a single final ack with dec1=5, dec2=10.
//  5. Reset asserted during SETTLE for code 2 -> rate_cur=0, cic_clear=1 and busy=1 in the cycle after reset.
//  6. With SETTLE_TIMEOUT_EN and TIMEOUT_CYCLES=100, no cic2_strobe -> rate_err and rate_ack at cycle 100
//     of SETTLE; out_gate=1.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC rate definitions: rate code type, sequencer state enum and decimation tables.
package cic_pkg;

    typedef logic [2:0] rate_code_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_CLEAR,
        ST_SETTLE
    } seq_state_t;

    localparam int unsigned RATE_CODE_MAX = 4;

    // Index 0 is the rightmost element.
    localparam logic [4:0][7:0] DEC1_TABLE = {8'd5, 8'd5, 8'd10, 8'd20, 8'd40};
    localparam logic [4:0][6:0] DEC2_TABLE = {7'd10, 7'd20, 7'd20, 7'd20, 7'd20};

endpackage

// File: rtl/cic_rate_lut.sv
// Combinational rate code -> (dec1, dec2, valid) lookup; invalid codes return zero decimations.
module cic_rate_lut
    import cic_pkg::*;
(
    input  logic [2:0] code,
    output logic [7:0] dec1,
    output logic [6:0] dec2,
    output logic       valid
);

    always_comb begin
        valid = (32'(code) <= RATE_CODE_MAX);
        dec1  = '0;
        dec2  = '0;
        if (valid) begin
            dec1 = DEC1_TABLE[code];
            dec2 = DEC2_TABLE[code];
        end
    end

endmodule

// File: rtl/cic_rate_sequencer.sv
// CIC decimation-rate change sequencer: clear, settle, then gate samples downstream.
// Optional SETTLE_TIMEOUT_EN adds a watchdog on missing cic2 strobes during SETTLE.
module cic_rate_sequencer
    import cic_pkg::*;
#(
    parameter int unsigned CLEAR_CYCLES   = 4,
    parameter int unsigned SETTLE_SAMPLES = 11,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] rate_req,
    input  logic       rate_load,
    input  logic       cic2_strobe,
    output logic [7:0] dec1,
    output logic [6:0] dec2,
    output logic       cic_clear,
    output logic       out_gate,
    output logic [2:0] rate_cur,
    output logic       rate_ack,
    output logic       busy,
    output logic       rate_err
);

    localparam int unsigned CW = $clog2(CLEAR_CYCLES + 1);
    localparam int unsigned SW = $clog2(SETTLE_SAMPLES + 1);

    seq_state_t state, state_n;
    logic [CW-1:0] clr_cnt, clr_cnt_n;
    logic [SW-1:0] settle_cnt, settle_cnt_n;
    logic          pend_v, pend_v_n;
    rate_code_t    pend_code, pend_code_n;
    rate_code_t    rate_n;
    logic          clear_n, gate_n, ack_n, err_n;
    logic          tout;

    logic [7:0]    req_dec1, nxt_dec1;
    logic [6:0]    req_dec2, nxt_dec2;
    logic          req_valid, nxt_valid;
    logic          req_ok, done, eff_v;
    rate_code_t    eff_code;

`ifdef SETTLE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt, tcnt_n;
`endif

    cic_rate_lut u_lut_req (
        .code  (rate_req),
        .dec1  (req_dec1),
        .dec2  (req_dec2),
        .valid (req_valid)
    );

    cic_rate_lut u_lut_next (
        .code  (rate_n),
        .dec1  (nxt_dec1),
        .dec2  (nxt_dec2),
        .valid (nxt_valid)
    );

    always_comb begin
        state_n      = state;
        clr_cnt_n    = clr_cnt;
        settle_cnt_n = settle_cnt;
        pend_v_n     = pend_v;
        pend_code_n  = pend_code;
        rate_n       = rate_cur;
        clear_n      = cic_clear;
        gate_n       = out_gate;
        ack_n        = 1'b0;
        req_ok       = rate_load && req_valid;
        err_n        = rate_load && !req_valid;
        done         = 1'b0;
        tout         = 1'b0;
        // A request arriving with the completing strobe counts as pending.
        eff_v        = req_ok || pend_v;
        eff_code     = req_ok ? rate_req : pend_code;
`ifdef SETTLE_TIMEOUT_EN
        tcnt_n       = tcnt;
`endif
        unique case (state)
            ST_RUN: begin
                clear_n = 1'b0;
                gate_n  = 1'b1;
                if (req_ok && rate_req != rate_cur) begin
                    rate_n    = rate_req;
                    state_n   = ST_CLEAR;
                    clr_cnt_n = '0;
                    clear_n   = 1'b1;
                    gate_n    = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (req_ok) begin
                    pend_v_n    = 1'b1;
                    pend_code_n = rate_req;
                end
                if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
                    state_n      = ST_SETTLE;
                    clear_n      = 1'b0;
                    settle_cnt_n = '0;
`ifdef SETTLE_TIMEOUT_EN
                    tcnt_n       = '0;
`endif
                end else begin
                    clr_cnt_n = clr_cnt + CW'(1);
                end
            end
            ST_SETTLE: begin
                if (req_ok) begin
                    pend_v_n    = 1'b1;
                    pend_code_n = rate_req;
                end
                if (cic2_strobe) begin
                    settle_cnt_n = settle_cnt + SW'(1);
                    done         = (settle_cnt == SW'(SETTLE_SAMPLES - 1));
                end
`ifdef SETTLE_TIMEOUT_EN
                tout   = !cic2_strobe && (tcnt == TW'(TIMEOUT_CYCLES - 1));
                tcnt_n = cic2_strobe ? '0 : tcnt + TW'(1);
`endif
                if (done) begin
                    pend_v_n = 1'b0;
                    if (eff_v && eff_code != rate_cur) begin
                        rate_n    = eff_code;
                        state_n   = ST_CLEAR;
                        clr_cnt_n = '0;
                        clear_n   = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                        ack_n   = 1'b1;
                        gate_n  = 1'b1;
                    end
                end else if (tout) begin
                    pend_v_n = 1'b0;
                    state_n  = ST_RUN;
                    ack_n    = 1'b1;
                    err_n    = 1'b1;
                    gate_n   = 1'b1;
                end
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            settle_cnt <= '0;
            pend_v     <= 1'b0;
            pend_code  <= '0;
            rate_cur   <= '0;
            dec1       <= DEC1_TABLE[0];
            dec2       <= DEC2_TABLE[0];
            cic_clear  <= 1'b1;
            out_gate   <= 1'b0;
            rate_ack   <= 1'b0;
            rate_err   <= 1'b0;
            busy       <= 1'b1;
`ifdef SETTLE_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_cnt_n;
            settle_cnt <= settle_cnt_n;
            pend_v     <= pend_v_n;
            pend_code  <= pend_code_n;
            rate_cur   <= rate_n;
            if (nxt_valid) begin
                dec1 <= nxt_dec1;
                dec2 <= nxt_dec2;
            end
            cic_clear  <= clear_n;
            out_gate   <= gate_n;
            rate_ack   <= ack_n;
            rate_err   <= err_n;
            busy       <= (state_n != ST_RUN);
`ifdef SETTLE_TIMEOUT_EN
            tcnt       <= tcnt_n;
`endif
        end
    end

endmodule
